// File: rtl/pwm_ramp_ctrl.sv
// PWM generator with debounced up/down buttons and a host target-load handshake.
// Ramp mode is enabled by defining PWM_RAMP_SOFTSTART_EN (default: direct load).
// Ports: clk, rst (async, active-high); increase_duty/decrease_duty raw buttons;
//   load_valid/load_duty/load_ready host handshake; duty_cycle, target_duty,
//   busy, PWM_OUT (registered).
module pwm_ramp_ctrl #(
   parameter int DEBOUNCE_DIV = 25000000,
   parameter int RAMP_PERIODS = 100,
   parameter int PERIOD       = 10,
   parameter int DUTY_MIN     = 1,
   parameter int DUTY_MAX     = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       increase_duty,
   input  logic       decrease_duty,
   input  logic       load_valid,
   input  logic [3:0] load_duty,
   output logic       load_ready,
   output logic [3:0] duty_cycle,
   output logic [3:0] target_duty,
   output logic       busy,
   output logic       PWM_OUT
);

   localparam int DW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
   localparam int PW = $clog2(PERIOD);
   localparam logic [3:0] DMIN = 4'(DUTY_MIN);
   localparam logic [3:0] DMAX = 4'(DUTY_MAX);

   if (RAMP_PERIODS < 1 || PERIOD < 2 || DEBOUNCE_DIV < 1 ||
       DUTY_MIN < 0 || DUTY_MAX > 15 || DUTY_MIN > DUTY_MAX) begin : g_bad_cfg
      $error("pwm_ramp_ctrl: bad parameters");
   end

   typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

   state_t          state, state_nxt;
   logic [1:0]      inc_sync, dec_sync;
   logic            inc_smp, dec_smp;
   logic            inc_ev, dec_ev;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [PW-1:0]   pwm_cnt;
   logic            bnd;
   logic            rst_done;
   logic            accept;

   assign tick   = (div_cnt == DW'(DEBOUNCE_DIV - 1));
   assign bnd    = (pwm_cnt == PW'(PERIOD - 1));
   assign accept = load_valid & load_ready;

   assign busy       = (state != IDLE);
   assign load_ready = rst_done & (state == IDLE);

   function automatic logic [3:0] clamp(input logic [3:0] v);
      if (v < DMIN)      return DMIN;
      else if (v > DMAX) return DMAX;
      else               return v;
   endfunction

   // Button path: 2-flop sync, slow sample, rising-edge event on sampled value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inc_sync <= '0;
         dec_sync <= '0;
         inc_smp  <= 1'b0;
         dec_smp  <= 1'b0;
         inc_ev   <= 1'b0;
         dec_ev   <= 1'b0;
         div_cnt  <= '0;
      end else begin
         inc_sync <= {inc_sync[0], increase_duty};
         dec_sync <= {dec_sync[0], decrease_duty};
         div_cnt  <= tick ? '0 : div_cnt + DW'(1);
         inc_ev   <= tick & inc_sync[1] & ~inc_smp;
         dec_ev   <= tick & dec_sync[1] & ~dec_smp;
         if (tick) begin
            inc_smp <= inc_sync[1];
            dec_smp <= dec_sync[1];
         end
      end
   end

   // Target: a load wins over buttons; simultaneous up+down cancels
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target_duty <= 4'd5;
      end else if (accept) begin
         target_duty <= clamp(load_duty);
      end else if (inc_ev & ~dec_ev) begin
         target_duty <= (target_duty >= DMAX) ? DMAX : target_duty + 4'd1;
      end else if (dec_ev & ~inc_ev) begin
         target_duty <= (target_duty <= DMIN) ? DMIN : target_duty - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt  <= '0;
         PWM_OUT  <= 1'b0;
         rst_done <= 1'b0;
         state    <= IDLE;
      end else begin
         pwm_cnt  <= bnd ? '0 : pwm_cnt + PW'(1);
         PWM_OUT  <= (32'(pwm_cnt) < 32'(duty_cycle));
         rst_done <= 1'b1;
         state    <= state_nxt;
      end
   end

`ifdef PWM_RAMP_SOFTSTART_EN
   localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

   logic [RW-1:0] ramp_cnt;
   logic          step;

   assign step = (state != IDLE) && (duty_cycle != target_duty) && bnd &&
                 (ramp_cnt == RW'(RAMP_PERIODS - 1));

   // Boundary counter survives direction changes; cleared once settled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ramp_cnt <= '0;
      end else if (state == IDLE || duty_cycle == target_duty) begin
         ramp_cnt <= '0;
      end else if (bnd) begin
         ramp_cnt <= step ? '0 : ramp_cnt + RW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_cycle <= 4'd5;
      end else if (step) begin
         duty_cycle <= (target_duty > duty_cycle) ? duty_cycle + 4'd1
                                                  : duty_cycle - 4'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (target_duty > duty_cycle)      state_nxt = RAMP_UP;
            else if (target_duty < duty_cycle) state_nxt = RAMP_DOWN;
         end
         RAMP_UP, RAMP_DOWN: begin
            if (target_duty == duty_cycle)     state_nxt = IDLE;
            else if (target_duty > duty_cycle) state_nxt = RAMP_UP;
            else                               state_nxt = RAMP_DOWN;
         end
         default: state_nxt = IDLE;
      endcase
   end
`else
   // Direct mode: duty snaps to target on each period boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_cycle <= 4'd5;
      end else if (bnd) begin
         duty_cycle <= target_duty;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      if (bnd)                           state_nxt = IDLE;
      else if (target_duty > duty_cycle) state_nxt = RAMP_UP;
      else if (target_duty < duty_cycle) state_nxt = RAMP_DOWN;
   end
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed steps plus random ops
// against a period-level reference model.
module tb_pwm_ramp_ctrl;

   localparam int P    = 10;
   localparam int RP   = 2;
   localparam int DD   = 4;
   localparam int DMIN = 1;
   localparam int DMAX = 9;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inc = 1'b0;
   logic       dec = 1'b0;
   logic       lv  = 1'b0;
   logic [3:0] ld  = 4'd0;
   logic       load_ready;
   logic [3:0] duty_cycle;
   logic [3:0] target_duty;
   logic       busy;
   logic       PWM_OUT;

   always #5 clk = ~clk;

   pwm_ramp_ctrl #(
      .DEBOUNCE_DIV(DD),
      .RAMP_PERIODS(RP),
      .PERIOD(P),
      .DUTY_MIN(DMIN),
      .DUTY_MAX(DMAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .increase_duty(inc),
      .decrease_duty(dec),
      .load_valid(lv),
      .load_duty(ld),
      .load_ready(load_ready),
      .duty_cycle(duty_cycle),
      .target_duty(target_duty),
      .busy(busy),
      .PWM_OUT(PWM_OUT)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clampf(input int v);
      if (v < DMIN) return DMIN;
      if (v > DMAX) return DMAX;
      return v;
   endfunction

   // Reference model state
   int cyc      = 0;
   int m_target = 5;
   int m_duty   = 5;
   bit m_busy   = 1'b0;
   bit m_ready  = 1'b0;
   bit obs_rdy  = 1'b0;
   bit accepted = 1'b0;
   bit btn_win  = 1'b0;
   int btn_exp  = 5;
   int steps[$];

   always @(posedge clk) begin
      int p_duty, p_target;
      bit p_ready, bnd, acc;
      p_duty   = m_duty;
      p_target = m_target;
`ifdef PWM_RAMP_SOFTSTART_EN
      p_ready  = obs_rdy;
`else
      p_ready  = m_ready;
`endif
      #1;
      if (rst) begin
         cyc = 0; m_target = 5; m_duty = 5;
         m_busy = 1'b0; m_ready = 1'b0;
         chk("rst_duty", duty_cycle, 5);
         chk("rst_target", target_duty, 5);
         chk("rst_busy", busy, 0);
         chk("rst_ready", load_ready, 0);
         chk("rst_pwm", PWM_OUT, 0);
      end else begin
         cyc++;
         bnd = (cyc % P == 0);
         acc = lv && p_ready;
         chk("pwm_out", PWM_OUT, 32'(((cyc - 1) % P) < p_duty));
`ifdef PWM_RAMP_SOFTSTART_EN
         if (!bnd) chk("duty_hold", duty_cycle, p_duty);
         else if (int'(duty_cycle) != p_duty) begin
            chk("step_dir", duty_cycle,
                p_duty + ((p_target > p_duty) ? 1 : -1));
            steps.push_back(cyc);
         end
         m_duty = int'(duty_cycle);
`else
         m_duty  = bnd ? p_target : p_duty;
         m_busy  = (p_target != p_duty) && !bnd;
         m_ready = !m_busy;
         chk("duty", duty_cycle, m_duty);
         chk("busy", busy, m_busy);
         chk("ready", load_ready, m_ready);
`endif
         if (acc) begin
            m_target = clampf(int'(ld));
            accepted = 1'b1;
         end else if (btn_win && int'(target_duty) != m_target) begin
            chk("btn_step", target_duty, btn_exp);
            m_target = btn_exp;
         end
         chk("target", target_duty, m_target);
      end
      obs_rdy = load_ready;
   end

   task automatic do_load(input int v);
      int i;
      @(negedge clk);
      accepted = 1'b0;
      lv = 1'b1;
      ld = 4'(v);
      i = 0;
      while (!accepted && i < 600) begin
         @(negedge clk);
         i++;
      end
      chk("load_accept", accepted, 1);
      lv = 1'b0;
   endtask

   task automatic do_btn(input bit up, input bit dn);
      if (up && dn)  btn_exp = m_target;
      else if (up)   btn_exp = (m_target >= DMAX) ? DMAX : m_target + 1;
      else           btn_exp = (m_target <= DMIN) ? DMIN : m_target - 1;
      btn_win = 1'b1;
      @(negedge clk);
      inc = up;
      dec = dn;
      repeat (3 * DD) @(negedge clk);
      inc = 1'b0;
      dec = 1'b0;
      repeat (3 * DD + 4) @(negedge clk);
      chk("btn_final", target_duty, btn_exp);
      btn_win = 1'b0;
   endtask

   task automatic settle(input string tag);
      int i;
      i = 0;
      @(negedge clk);
      while ((busy || duty_cycle != target_duty) && i < 600) begin
         @(negedge clk);
         i++;
      end
      chk(tag, duty_cycle, m_target);
   endtask

   task automatic wait_duty(input int d);
      int i;
      i = 0;
      while (int'(duty_cycle) != d && i < 600) begin
         @(negedge clk);
         i++;
      end
      chk("wait_duty", duty_cycle, d);
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_duty", duty_cycle, 5);
      chk("async_target", target_duty, 5);
      chk("async_busy", busy, 0);
      chk("async_ready", load_ready, 0);
      chk("async_pwm", PWM_OUT, 0);
      repeat (2 * P + 3) @(negedge clk);
      rst = 1'b0;
      chk("ready_low_pre_clk", load_ready, 0);
      @(posedge clk);
      #2;
      chk("ready_after_rst", load_ready, 1);
   endtask

   initial begin
      int hi;
      int r;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("ready_low_pre_clk", load_ready, 0);
      @(posedge clk);
      #2;
      chk("ready_after_rst", load_ready, 1);

`ifdef PWM_RAMP_SOFTSTART_EN
      steps.delete();
      do_load(8);
      repeat (2) @(negedge clk);
      chk("ready_drop", load_ready, 0);
      settle("ramp_to_8");
      chk("step_count", steps.size(), 3);
      for (int i = 1; i < steps.size(); i++)
         chk("step_gap", steps[i] - steps[i-1], RP * P);
      @(negedge clk);
      chk("ready_back", load_ready, 1);
`else
      do_load(2);
      wait_duty(2);
      repeat (P) @(negedge clk);
      hi = 0;
      for (int i = 0; i < P; i++) begin
         @(negedge clk);
         hi += int'(PWM_OUT);
      end
      chk("pwm_high_count", hi, 2);
`endif

      do_load(15);
      chk("clamp_hi", target_duty, 9);
      settle("settle_hi");
      do_load(0);
      chk("clamp_lo", target_duty, 1);
      settle("settle_lo");

      do_btn(1'b1, 1'b0);
      chk("inc_once", target_duty, 2);
      do_btn(1'b1, 1'b1);
      chk("both_drop", target_duty, 2);
      do_btn(1'b0, 1'b1);
      chk("dec_once", target_duty, 1);
      do_btn(1'b0, 1'b1);
      chk("dec_sat", target_duty, 1);
      settle("settle_btn");

`ifdef PWM_RAMP_SOFTSTART_EN
      do_load(5);
      settle("settle_5");
      do_load(9);
      wait_duty(7);
      do_btn(1'b0, 1'b1);
      do_btn(1'b0, 1'b1);
      do_btn(1'b0, 1'b1);
      chk("redirect_tgt", target_duty, 6);
      settle("redirect_settle");
      do_load(9);
      wait_duty(7);
`else
      do_load(9);
      @(negedge clk);
      @(negedge clk);
`endif
      reset_pulse();

      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 5));
         if (r <= 2)      do_load(int'($urandom_range(0, 15)));
         else if (r == 3) do_btn(1'b1, 1'b0);
         else if (r == 4) do_btn(1'b0, 1'b1);
         else             do_btn(1'b1, 1'b1);
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      settle("final_settle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
